// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the N-input arbitrating output register.
package arb_mux_n_pkg;

    // Arbitration mode selectors for the MODE parameter
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Supported channel-count range
    localparam int MIN_NUM_IN = 2;
    localparam int MAX_NUM_IN = 16;

    // Ceiling log2, usable in parameter and localparam expressions
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Channel-side and output-side handshake bundle for arb_mux_n.
interface arb_mux_n_if
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = clog2(NUM_IN);

    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    // Producer/consumer side: drives requests and downstream accept
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/arb_mux_n_rr_grant.sv
// Combinational grant picker: first requester at or after a start index,
// or lowest requester when fixed priority is selected.
module rr_grant
    import arb_mux_n_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    input  logic              i_mode,
    output logic [NUM_IN-1:0] o_grant,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_any
);

    logic [SEL_W-1:0] w_base;
    logic [SEL_W-1:0] w_cand;

    // Scan channels from the start index, wrapping naturally in SEL_W bits
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        w_base  = (i_mode == 1'(MODE_FIXED)) ? '0 : i_ptr;
        for (int off = 0; off < NUM_IN; off++) begin
            w_cand = w_base + SEL_W'(off);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbiter feeding a single registered output with
// valid/ready flow control and full one-word-per-cycle throughput.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int MODE   = MODE_RR
) (
    input logic         clk,
    input logic         rst_n,
    arb_mux_n_if.slave  bus
);

    localparam int SEL_W = clog2(NUM_IN);

    // Reject unsupported configurations at elaboration
    generate
        if (NUM_IN < MIN_NUM_IN || NUM_IN > MAX_NUM_IN || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
            $error("arb_mux_n: NUM_IN must be a power of two in 2..16");
        end
        if (MODE != MODE_RR && MODE != MODE_FIXED) begin : g_bad_mode
            $error("arb_mux_n: MODE must be 0 (round-robin) or 1 (fixed)");
        end
    endgenerate

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load;
    logic [NUM_IN-1:0]   w_grant;
    logic [SEL_W-1:0]    w_idx;
    logic                w_any;
    logic [NUM_IN-1:0]   w_in_ready;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_sel_data;

    rr_grant #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_grant (
        .i_req   (bus.in_valid),
        .i_ptr   (r_ptr),
        .i_mode  (1'(MODE)),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Output register can take a new word when empty or being drained;
    // while in reset nothing is accepted
    always_comb begin
        w_load     = !r_out_valid || bus.out_ready;
        w_in_ready = (rst_n && w_load && w_any) ? w_grant : '0;
        w_xfer     = |(bus.in_valid & w_in_ready);
    end

    // AND-OR select of the granted channel's data under the one-hot grant
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel_data = w_sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    // Output register and round-robin pointer; reset wins over any transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_idx;
                if (MODE == MODE_RR) begin
                    r_ptr <= w_idx + SEL_W'(1);
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed self-checking bench for arb_mux_n: one round-robin instance
// and one fixed-priority instance, both 4 channels of 64 bits.
module tb_arb_mux_n;
    import arb_mux_n_pkg::*;

    logic clk;
    logic rst0_n;
    logic rst1_n;
    int   testsRun;
    int   testsFailed;

    arb_mux_n_if #(.WIDTH(64), .NUM_IN(4)) bus0 ();
    arb_mux_n_if #(.WIDTH(64), .NUM_IN(4)) bus1 ();

    arb_mux_n #(.WIDTH(64), .NUM_IN(4), .MODE(MODE_RR)) u_dut_rr (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (bus0)
    );

    arb_mux_n #(.WIDTH(64), .NUM_IN(4), .MODE(MODE_FIXED)) u_dut_fixed (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive the round-robin instance's request and accept inputs, then let them settle
    task automatic applyStimulus(input logic [3:0] valid, input logic outReady);
        bus0.in_valid  = valid;
        bus0.out_ready = outReady;
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        rst0_n         = 1'b0;
        rst1_n         = 1'b0;
        bus0.in_data   = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        bus1.in_data   = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        bus1.in_valid  = 4'b1111;
        bus1.out_ready = 1'b1;
        applyStimulus(4'b1111, 1'b1);

        // Reset held two cycles with every channel requesting
        stepCycle();
        stepCycle();
        checkOutput("rst_in_ready", 64'(bus0.in_ready), 64'h0);
        checkOutput("rst_out_valid", 64'(bus0.out_valid), 64'h0);
        checkOutput("rst_out_data", bus0.out_data, 64'h0);
        checkOutput("rst_out_sel", 64'(bus0.out_sel), 64'h0);

        // Round-robin rotation 0,1,2,3,0
        rst0_n = 1'b1;
        #1;
        checkOutput("rr_first_ready", 64'(bus0.in_ready), 64'h1);
        stepCycle();
        checkOutput("rr0_valid", 64'(bus0.out_valid), 64'h1);
        checkOutput("rr0_sel", 64'(bus0.out_sel), 64'h0);
        checkOutput("rr0_data", bus0.out_data, 64'hA0);
        stepCycle();
        checkOutput("rr1_sel", 64'(bus0.out_sel), 64'h1);
        checkOutput("rr1_data", bus0.out_data, 64'hA1);
        stepCycle();
        checkOutput("rr2_sel", 64'(bus0.out_sel), 64'h2);
        checkOutput("rr2_data", bus0.out_data, 64'hA2);
        stepCycle();
        checkOutput("rr3_sel", 64'(bus0.out_sel), 64'h3);
        checkOutput("rr3_data", bus0.out_data, 64'hA3);
        stepCycle();
        checkOutput("rr4_sel", 64'(bus0.out_sel), 64'h0);
        checkOutput("rr4_data", bus0.out_data, 64'hA0);
        checkOutput("rr4_valid", 64'(bus0.out_valid), 64'h1);

        // Backpressure for three cycles holds the word and blocks inputs
        applyStimulus(4'b1111, 1'b0);
        checkOutput("bp_in_ready", 64'(bus0.in_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("bp_valid", 64'(bus0.out_valid), 64'h1);
            checkOutput("bp_sel", 64'(bus0.out_sel), 64'h0);
            checkOutput("bp_data", bus0.out_data, 64'hA0);
            checkOutput("bp_hold_ready", 64'(bus0.in_ready), 64'h0);
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("bp_release_ready", 64'(bus0.in_ready), 64'h2);
        stepCycle();
        checkOutput("bp_next_sel", 64'(bus0.out_sel), 64'h1);
        checkOutput("bp_next_data", bus0.out_data, 64'hA1);

        // Advance pointer to 3, then only channels 0 and 1 request
        stepCycle();
        checkOutput("wrap_pre_sel", 64'(bus0.out_sel), 64'h2);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("wrap_ready", 64'(bus0.in_ready), 64'h1);
        stepCycle();
        checkOutput("wrap_sel", 64'(bus0.out_sel), 64'h0);
        checkOutput("wrap_data", bus0.out_data, 64'hA0);
        checkOutput("skip_ready", 64'(bus0.in_ready), 64'h2);
        stepCycle();
        checkOutput("skip_sel", 64'(bus0.out_sel), 64'h1);

        // No requests: output drains, data and select hold
        applyStimulus(4'b0000, 1'b1);
        checkOutput("idle_ready", 64'(bus0.in_ready), 64'h0);
        stepCycle();
        checkOutput("drain_valid", 64'(bus0.out_valid), 64'h0);
        checkOutput("drain_sel", 64'(bus0.out_sel), 64'h1);
        checkOutput("drain_data", bus0.out_data, 64'hA1);

        // Pointer is 2: one transfer leaves a word held, then reset mid-flight
        applyStimulus(4'b1111, 1'b1);
        checkOutput("pre_rst_ready", 64'(bus0.in_ready), 64'h4);
        stepCycle();
        checkOutput("pre_rst_sel", 64'(bus0.out_sel), 64'h2);
        rst0_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 64'(bus0.in_ready), 64'h0);
        stepCycle();
        checkOutput("mid_rst_valid", 64'(bus0.out_valid), 64'h0);
        checkOutput("mid_rst_sel", 64'(bus0.out_sel), 64'h0);
        checkOutput("mid_rst_data", bus0.out_data, 64'h0);
        rst0_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 64'(bus0.in_ready), 64'h1);
        stepCycle();
        checkOutput("post_rst_sel", 64'(bus0.out_sel), 64'h0);
        checkOutput("post_rst_data", bus0.out_data, 64'hA0);

        // Fixed priority: channel 1 always beats channel 3
        applyStimulus(4'b0000, 1'b1);
        bus1.in_valid = 4'b1010;
        rst1_n        = 1'b1;
        #1;
        checkOutput("fx_ready", 64'(bus1.in_ready), 64'h2);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("fx_sel", 64'(bus1.out_sel), 64'h1);
            checkOutput("fx_data", bus1.out_data, 64'hB1);
            checkOutput("fx_starve_ready", 64'(bus1.in_ready), 64'h2);
        end
        bus1.in_valid = 4'b1000;
        #1;
        checkOutput("fx_ch3_ready", 64'(bus1.in_ready), 64'h8);
        stepCycle();
        checkOutput("fx_ch3_sel", 64'(bus1.out_sel), 64'h3);
        checkOutput("fx_ch3_data", bus1.out_data, 64'hB3);
        bus1.in_valid = 4'b1011;
        #1;
        checkOutput("fx_low_ready", 64'(bus1.in_ready), 64'h1);
        stepCycle();
        checkOutput("fx_low_sel", 64'(bus1.out_sel), 64'h0);
        checkOutput("fx_low_data", bus1.out_data, 64'hB0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
